uriscv_branch_pred: RTL and testbench
=====================================

Name: uriscv_branch_pred

Overview:
- Parametrised branch prediction and resolution unit for the uRISC-V core.
- Fetch side: registered taken/target prediction from a direct-mapped BTB plus a table of 2-bit saturating counters (BHT).
- Execute side: resolves JAL, JALR and Bxx with the same decode and compare rules as the existing branch unit, detects mispredicts, issues a registered redirect and trains the tables.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries (power of two, >=2).
- BHT_ENTRIES, 64, number of 2-bit counters (power of two, >=2).
- RAS_DEPTH, 4, return stack entries (power of two); used only with the optional feature.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset
- fetch_valid_i  in  1  fetch PC lookup request
- fetch_pc_i  in  32  fetch PC (word aligned)
- pred_valid_o  out  1  prediction valid, one cycle after request
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  32  predicted next PC (fetch_pc+4 when not taken)
- res_valid_i  in  1  instruction at execute is valid
- res_pc_i  in  32  PC of resolving instruction
- res_opcode_i  in  32  instruction word
- res_rs1_val_i  in  32  rs1 operand
- res_rs2_val_i  in  32  rs2 operand
- res_pred_taken_i  in  1  prediction carried with this instruction
- res_pred_target_i  in  32  predicted next PC carried with it
- mispredict_o  out  1  redirect strobe, one cycle after resolve
- redirect_pc_o  out  32  correct next PC
- res_taken_o  out  1  registered actual outcome, for perf counters

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - BTB valid bits 0;
  - BHT counters 2'b01 (weakly not-taken);
  - RAS pointer 0.
- Indexing:
  - BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[31:log2(BTB_ENTRIES)+2].
  - BHT index = pc[log2(BHT_ENTRIES)+1:2].
- BTB entry fields: valid, tag, target[31:0], kind (0 = cond branch, 1 = JAL/JALR, 2 = return).
- Prediction, latency 1:
  - pred_valid_o = registered fetch_valid_i.
  - hit = valid && tag match.
  - taken = hit && (kind != cond || counter[1]).
  - target = taken ? entry target : fetch_pc_i+4.
  - Outputs hold their value when fetch_valid_i is low, except pred_valid_o, which drops.
- Resolution (combinational compute, registered outputs):
  - Opcode[6:2]: 11011 = JAL, 11001 = JALR, 11000 = Bxx.
  - JAL target = pc + J-immediate. JALR target = (rs1 + I-immediate) with bit0 cleared. Bxx target = pc + B-immediate.
  - Bxx funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; funct3 010/011 never taken.
  - Non-control opcodes: taken = 0.
  - actual_next = taken ? target : pc+4, 32-bit wrap-around arithmetic.
  - mispredict = res_valid_i && (res_pred_target_i != actual_next || res_pred_taken_i != taken).
  - Next cycle: mispredict_o = mispredict; redirect_pc_o = actual_next; res_taken_o = taken && res_valid_i.
  - mispredict_o is a single-cycle pulse per resolving instruction.
- Training, on the res_valid_i edge:
  - Bxx: counter saturates at 00/11 (taken inc, not-taken dec).
  - Any taken control instruction: write BTB entry (valid = 1, tag, target, kind). JALR with rd=x0 and rs1 in {x1,x5} gets kind = return; other JAL/JALR get kind = 1.
  - Not-taken Bxx: counter update only; BTB untouched.
  - Non-control instruction hitting a BTB entry: invalidate that entry (alias removal).
- Simultaneous fetch lookup and training on the same index: the lookup sees pre-update contents (read-before-write).
- Reset mid-operation: tables are cleared immediately; no pending redirect survives.

Optional Feature:
- Macro: URISCV_BRANCH_PRED_RAS_EN.
- With the macro:
  - RAS_DEPTH-entry return-address stack, updated at resolve time.
  - Push res_pc_i+4 on JAL/JALR with rd in {x1,x5}; pop on a kind = return resolve.
  - Push and pop in the same cycle: replace top.
  - Overflow: the pointer wraps and overwrites the oldest entry.
  - Empty: no pop; prediction falls back to the BTB target.
  - A BTB hit of kind = return predicts taken to the RAS top.
- Without the macro: no RAS storage; kind = return predicts the stored BTB target.

Test Plan:
- Reset, then fetch 0x100 -> pred_valid_o=1, pred_taken_o=0, pred_target_o=0x104 next cycle.
- Resolve JAL at 0x100, imm +0x40, pred_taken=0 -> mispredict_o=1, redirect_pc_o=0x140; later fetch 0x100 -> taken, target 0x140.
- BEQ at 0x200 (+0x20), rs1=rs2=5, resolved three times -> counter 01->10->11->11; first resolve mispredicts to 0x220, then fetch 0x200 predicts taken.
- BLT at 0x300, rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU same operands -> not taken, redirect_pc_o=0x304 when predicted taken.
- JALR rs1=0x1001, imm=0 -> target 0x1000. Same-cycle fetch of the trained PC -> old (not-taken) prediction returned.
- With the macro: call at 0x400 (JAL x1), then return JALR x0,0(x1) -> return predicted to 0x404. Five calls with RAS_DEPTH=4 -> oldest return falls back to the BTB target.

Source files
------------

// File: rtl/uriscv_branch_pred.sv
// uRISC-V branch predictor. Fetch side: BTB and 2-bit BHT lookup. Execute side: resolves jumps and branches, then redirects and trains.
// Define URISCV_BRANCH_PRED_RAS_EN to add a return-address stack for kind=return predictions.
module uriscv_branch_pred #(
    parameter int BTB_ENTRIES = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_pc_i,
    input  logic [31:0] res_opcode_i,
    input  logic [31:0] res_rs1_val_i,
    input  logic [31:0] res_rs2_val_i,
    input  logic        res_pred_taken_i,
    input  logic [31:0] res_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic        res_taken_o
);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int TAG_W  = 30 - BTB_IW;
    localparam logic [1:0] KIND_COND = 2'd0;
    localparam logic [1:0] KIND_JUMP = 2'd1;
    localparam logic [1:0] KIND_RET  = 2'd2;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [31:0]            btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_kind_q   [BTB_ENTRIES];
    logic [1:0]             bht_q        [BHT_ENTRIES];

    logic        pred_valid_q, pred_taken_q, mispredict_q, res_taken_q;
    logic [31:0] pred_target_q, redirect_pc_q;

    logic [4:0]        opc, rd, rs1;
    logic [2:0]        funct3;
    logic              is_jal, is_jalr, is_br, is_ctrl, br_cond, r_taken, r_hit, mispredict_d;
    logic [31:0]       imm_j, imm_i, imm_b, r_target, r_next;
    logic [1:0]        r_kind;
    logic [BTB_IW-1:0] r_idx, f_idx;
    logic [BHT_IW-1:0] r_bidx, f_bidx;
    logic [TAG_W-1:0]  r_tag;
    logic              f_hit, f_taken;
    logic [31:0]       f_target;
    logic              unused_opc;

    assign unused_opc = ^res_opcode_i[1:0];
    assign opc    = res_opcode_i[6:2];
    assign rd     = res_opcode_i[11:7];
    assign funct3 = res_opcode_i[14:12];
    assign rs1    = res_opcode_i[19:15];
    assign imm_j  = {{12{res_opcode_i[31]}}, res_opcode_i[19:12], res_opcode_i[20], res_opcode_i[30:21], 1'b0};
    assign imm_i  = {{20{res_opcode_i[31]}}, res_opcode_i[31:20]};
    assign imm_b  = {{20{res_opcode_i[31]}}, res_opcode_i[7], res_opcode_i[30:25], res_opcode_i[11:8], 1'b0};
    assign is_jal  = (opc == 5'b11011);
    assign is_jalr = (opc == 5'b11001);
    assign is_br   = (opc == 5'b11000);
    assign is_ctrl = is_jal || is_jalr || is_br;

    assign r_idx  = res_pc_i[BTB_IW+1:2];
    assign r_tag  = res_pc_i[31:BTB_IW+2];
    assign r_bidx = res_pc_i[BHT_IW+1:2];
    assign r_hit  = btb_valid_q[r_idx] && (btb_tag_q[r_idx] == r_tag);
    assign f_idx  = fetch_pc_i[BTB_IW+1:2];
    assign f_bidx = fetch_pc_i[BHT_IW+1:2];

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (res_rs1_val_i == res_rs2_val_i);
            3'b001:  br_cond = (res_rs1_val_i != res_rs2_val_i);
            3'b100:  br_cond = ($signed(res_rs1_val_i) <  $signed(res_rs2_val_i));
            3'b101:  br_cond = ($signed(res_rs1_val_i) >= $signed(res_rs2_val_i));
            3'b110:  br_cond = (res_rs1_val_i <  res_rs2_val_i);
            3'b111:  br_cond = (res_rs1_val_i >= res_rs2_val_i);
            default: br_cond = 1'b0;
        endcase
        r_taken  = is_jal || is_jalr || (is_br && br_cond);
        r_target = res_pc_i + imm_b;
        if (is_jal)  r_target = res_pc_i + imm_j;
        if (is_jalr) r_target = (res_rs1_val_i + imm_i) & ~32'd1;
        r_next = r_taken ? r_target : res_pc_i + 32'd4;
        mispredict_d = res_valid_i && ((res_pred_target_i != r_next) || (res_pred_taken_i != r_taken));
        r_kind = is_br ? KIND_COND : KIND_JUMP;
        if (is_jalr && rd == 5'd0 && (rs1 == 5'd1 || rs1 == 5'd5)) r_kind = KIND_RET;
    end

`ifdef URISCV_BRANCH_PRED_RAS_EN
    localparam int RAS_IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CW = $clog2(RAS_DEPTH + 1);
    logic [31:0]       ras_q [RAS_DEPTH];
    logic [RAS_IW-1:0] ras_ptr_q, ras_top;
    logic [RAS_CW-1:0] ras_cnt_q;
    logic              ras_push, ras_pop;

    // ras_ptr_q is the next free slot; the count saturates so overflow silently drops the oldest return.
    assign ras_top  = ras_ptr_q - 1'b1;
    assign ras_push = res_valid_i && (is_jal || is_jalr) && (rd == 5'd1 || rd == 5'd5);
    assign ras_pop  = res_valid_i && (r_kind == KIND_RET) && (ras_cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (ras_push && ras_pop) begin
            ras_q[ras_top] <= res_pc_i + 32'd4;
        end else if (ras_push) begin
            ras_q[ras_ptr_q] <= res_pc_i + 32'd4;
            ras_ptr_q        <= ras_ptr_q + 1'b1;
            if (ras_cnt_q != RAS_CW'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
        end else if (ras_pop) begin
            ras_ptr_q <= ras_top;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end
`endif

    always_comb begin
        f_hit    = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == fetch_pc_i[31:BTB_IW+2]);
        f_taken  = f_hit && ((btb_kind_q[f_idx] != KIND_COND) || bht_q[f_bidx][1]);
        f_target = fetch_pc_i + 32'd4;
        if (f_taken) begin
            f_target = btb_target_q[f_idx];
`ifdef URISCV_BRANCH_PRED_RAS_EN
            if (btb_kind_q[f_idx] == KIND_RET && ras_cnt_q != '0) f_target = ras_q[ras_top];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (res_valid_i && is_br) begin
            if (r_taken && bht_q[r_bidx] != 2'b11)       bht_q[r_bidx] <= bht_q[r_bidx] + 2'b01;
            else if (!r_taken && bht_q[r_bidx] != 2'b00) bht_q[r_bidx] <= bht_q[r_bidx] - 2'b01;
        end
    end

    // Non-control instructions that hit were aliased onto a stale entry; drop it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   btb_valid_q <= '0;
        else if (res_valid_i && r_taken)               btb_valid_q[r_idx] <= 1'b1;
        else if (res_valid_i && !is_ctrl && r_hit)     btb_valid_q[r_idx] <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (res_valid_i && r_taken) begin
            btb_tag_q[r_idx]    <= r_tag;
            btb_target_q[r_idx] <= r_target;
            btb_kind_q[r_idx]   <= r_kind;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            res_taken_q   <= 1'b0;
        end else begin
            pred_valid_q <= fetch_valid_i;
            if (fetch_valid_i) begin
                pred_taken_q  <= f_taken;
                pred_target_q <= f_target;
            end
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= r_next;
            res_taken_q   <= r_taken && res_valid_i;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;
    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_pc_q;
    assign res_taken_o   = res_taken_q;
endmodule

// File: tb/tb_uriscv_branch_pred.sv
// Self-checking bench for uriscv_branch_pred: directed test-plan steps, then randomized traffic against a table-level reference model.
module tb_uriscv_branch_pred;
    localparam int BTB_N = 16;
    localparam int BHT_N = 64;
    localparam int RAS_N = 4;
    localparam int K_JAL = 0, K_JALR = 1, K_BR = 2, K_OTH = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fetch_valid = 1'b0, res_valid = 1'b0, res_pred_taken = 1'b0;
    logic [31:0] fetch_pc = '0, res_pc = '0, res_opcode = '0, rs1_val = '0, rs2_val = '0, res_pred_target = '0;
    logic        pred_valid, pred_taken, mispredict, res_taken;
    logic [31:0] pred_target, redirect_pc;

    always #5 clk = ~clk;

    uriscv_branch_pred #(.BTB_ENTRIES(BTB_N), .BHT_ENTRIES(BHT_N), .RAS_DEPTH(RAS_N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc),
        .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .res_valid_i(res_valid), .res_pc_i(res_pc), .res_opcode_i(res_opcode),
        .res_rs1_val_i(rs1_val), .res_rs2_val_i(rs2_val),
        .res_pred_taken_i(res_pred_taken), .res_pred_target_i(res_pred_target),
        .mispredict_o(mispredict), .redirect_pc_o(redirect_pc), .res_taken_o(res_taken)
    );

    int total = 0, bad = 0;

    // Reference model: tables as plain arrays indexed arithmetically, RAS as a bounded queue.
    logic        m_v   [BTB_N];
    logic [31:0] m_tag [BTB_N];
    logic [31:0] m_tgt [BTB_N];
    int          m_kind[BTB_N];
    int          m_ctr [BHT_N];
    logic [31:0] m_ras [$];

    // Instruction at execute, described at a high level and encoded on each tick.
    int          d_k = K_OTH;
    logic [31:0] d_imm = '0;
    logic [2:0]  d_f3 = '0;
    logic [4:0]  d_rd = '0, d_rs1 = '0;

    logic        e_pv = 0, e_pt = 0, e_mp = 0, e_rt = 0, chk_rd = 0;
    logic [31:0] e_ptg = '0, e_rd = '0;

    logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h200, 32'h204, 32'h1200, 32'h300, 32'h7C, 32'hFFFF_FFFC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < BTB_N; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_kind[i] = 0; end
        for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
        m_ras.delete();
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i, b;
        logic hit;
        i = int'((pc / 4) % BTB_N);
        b = int'((pc / 4) % BHT_N);
        hit = m_v[i] && (m_tag[i] == pc / (4 * BTB_N));
        tk = hit && (m_kind[i] != 0 || m_ctr[b] >= 2);
        tg = pc + 4;
        if (tk) begin
            tg = m_tgt[i];
`ifdef URISCV_BRANCH_PRED_RAS_EN
            if (m_kind[i] == 2 && m_ras.size() > 0) tg = m_ras[$];
`endif
        end
    endfunction

    function automatic logic [31:0] encode();
        case (d_k)
            K_JAL:   return {d_imm[20], d_imm[10:1], d_imm[11], d_imm[19:12], d_rd, 7'b1101111};
            K_JALR:  return {d_imm[11:0], d_rs1, 3'b000, d_rd, 7'b1100111};
            K_BR:    return {d_imm[12], d_imm[10:5], 5'd2, d_rs1, d_f3, d_imm[4:1], d_imm[11], 7'b1100011};
            default: return {d_imm[24:0], 7'b0010011};
        endcase
    endfunction

    function automatic void m_outcome(output logic tk, output logic [31:0] tg);
        tk = 0;
        tg = res_pc + d_imm;
        if (d_k == K_JAL) tk = 1;
        if (d_k == K_JALR) begin tk = 1; tg = (rs1_val + d_imm) & ~32'd1; end
        if (d_k == K_BR) begin
            case (d_f3)
                3'd0: tk = (rs1_val == rs2_val);
                3'd1: tk = (rs1_val != rs2_val);
                3'd4: tk = ($signed(rs1_val) <  $signed(rs2_val));
                3'd5: tk = ($signed(rs1_val) >= $signed(rs2_val));
                3'd6: tk = (rs1_val <  rs2_val);
                3'd7: tk = (rs1_val >= rs2_val);
                default: tk = 0;
            endcase
        end
    endfunction

    function automatic void m_train(input logic tk, input logic [31:0] tg);
        int i, b, kind;
        logic [31:0] t;
        i = int'((res_pc / 4) % BTB_N);
        b = int'((res_pc / 4) % BHT_N);
        t = res_pc / (4 * BTB_N);
        kind = (d_k == K_BR) ? 0 : 1;
        if (d_k == K_JALR && d_rd == 0 && (d_rs1 == 1 || d_rs1 == 5)) kind = 2;
        if (d_k == K_BR) m_ctr[b] = tk ? ((m_ctr[b] < 3) ? m_ctr[b] + 1 : 3) : ((m_ctr[b] > 0) ? m_ctr[b] - 1 : 0);
        if (tk) begin m_v[i] = 1; m_tag[i] = t; m_tgt[i] = tg; m_kind[i] = kind; end
        else if (d_k == K_OTH && m_v[i] && m_tag[i] == t) m_v[i] = 0;
`ifdef URISCV_BRANCH_PRED_RAS_EN
        if (kind == 2 && m_ras.size() > 0) void'(m_ras.pop_back());
        if ((d_k == K_JAL || d_k == K_JALR) && (d_rd == 1 || d_rd == 5)) begin
            m_ras.push_back(res_pc + 4);
            if (m_ras.size() > RAS_N) void'(m_ras.pop_front());
        end
`endif
    endfunction

    task automatic tick();
        logic pt, at;
        logic [31:0] ptg, atg, nxt;
        res_opcode = encode();
        if (fetch_valid) begin m_predict(fetch_pc, pt, ptg); e_pt = pt; e_ptg = ptg; end
        e_pv = fetch_valid;
        m_outcome(at, atg);
        nxt = at ? atg : res_pc + 4;
        e_mp = res_valid && (res_pred_target != nxt || res_pred_taken != at);
        e_rt = at && res_valid;
        e_rd = nxt;
        chk_rd = res_valid;
        @(posedge clk); #1;
        if (res_valid) m_train(at, atg);
        chk("pred_valid", 32'(pred_valid), 32'(e_pv));
        chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("pred_target", pred_target, e_ptg);
        chk("mispredict", 32'(mispredict), 32'(e_mp));
        chk("res_taken", 32'(res_taken), 32'(e_rt));
        if (chk_rd) chk("redirect_pc", redirect_pc, e_rd);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        m_clear();
        e_pv = 0; e_pt = 0; e_ptg = 0; e_mp = 0; e_rt = 0;
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_res_taken", 32'(res_taken), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc, input int k, input logic [31:0] imm,
                           input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [31:0] a, input logic [31:0] b, input logic pt, input logic [31:0] ptg);
        res_valid = v; res_pc = pc; d_k = k; d_imm = imm; d_f3 = f3; d_rd = rd; d_rs1 = rs1;
        rs1_val = a; rs2_val = b; res_pred_taken = pt; res_pred_target = ptg;
    endtask

    task automatic model_pred();
        logic pt;
        logic [31:0] ptg;
        m_predict(res_pc, pt, ptg);
        res_pred_taken = pt; res_pred_target = ptg;
    endtask

    initial begin
        m_clear();
        #2;
        do_reset();

        fetch_valid = 1; fetch_pc = 32'h100; tick();
        chk("tp_f100_taken", 32'(pred_taken), 32'd0);
        chk("tp_f100_target", pred_target, 32'h104);
        fetch_valid = 0;

        set_res(1, 32'h100, K_JAL, 32'h40, 0, 0, 0, 0, 0, 0, 32'h104); tick();
        chk("tp_jal_mp", 32'(mispredict), 32'd1);
        chk("tp_jal_redirect", redirect_pc, 32'h140);
        res_valid = 0; fetch_valid = 1; fetch_pc = 32'h100; tick();
        chk("tp_jal_pred", pred_target, 32'h140);
        fetch_valid = 0;

        set_res(1, 32'h200, K_BR, 32'h20, 3'd0, 0, 5'd3, 5, 5, 0, 32'h204); tick();
        chk("tp_beq_redirect", redirect_pc, 32'h220);
        set_res(1, 32'h200, K_BR, 32'h20, 3'd0, 0, 5'd3, 5, 5, 1, 32'h220); tick();
        tick();
        res_valid = 0; fetch_valid = 1; fetch_pc = 32'h200; tick();
        chk("tp_beq_pred_taken", 32'(pred_taken), 32'd1);
        chk("tp_beq_pred_target", pred_target, 32'h220);
        fetch_valid = 0;
        set_res(1, 32'h200, K_BR, 32'h20, 3'd0, 0, 5'd3, 5, 6, 1, 32'h220); tick();
        chk("tp_beq_nt_redirect", redirect_pc, 32'h204);
        res_valid = 0; fetch_valid = 1; fetch_pc = 32'h200; tick();
        chk("tp_beq_sat_taken", 32'(pred_taken), 32'd1);
        fetch_valid = 0;

        set_res(1, 32'h300, K_BR, 32'h10, 3'd4, 0, 5'd3, 32'hFFFF_FFFF, 1, 0, 32'h304); tick();
        chk("tp_blt_taken", 32'(res_taken), 32'd1);
        set_res(1, 32'h300, K_BR, 32'h10, 3'd6, 0, 5'd3, 32'hFFFF_FFFF, 1, 1, 32'h310); tick();
        chk("tp_bltu_taken", 32'(res_taken), 32'd0);
        chk("tp_bltu_redirect", redirect_pc, 32'h304);

        set_res(1, 32'h600, K_JALR, 32'h0, 0, 0, 5'd2, 32'h1001, 0, 0, 32'h604);
        fetch_valid = 1; fetch_pc = 32'h600; tick();
        chk("tp_jalr_redirect", redirect_pc, 32'h1000);
        chk("tp_rbw_taken", 32'(pred_taken), 32'd0);
        chk("tp_rbw_target", pred_target, 32'h604);
        res_valid = 0; tick();
        chk("tp_jalr_pred", pred_target, 32'h1000);
        fetch_valid = 0;

`ifdef URISCV_BRANCH_PRED_RAS_EN
        set_res(1, 32'h400, K_JAL, 32'h100, 0, 5'd1, 0, 0, 0, 0, 32'h404); tick();
        set_res(1, 32'h508, K_JALR, 32'h0, 0, 5'd0, 5'd1, 32'h404, 0, 0, 32'h50C); tick();
        set_res(1, 32'h420, K_JAL, 32'h100, 0, 5'd1, 0, 0, 0, 0, 32'h424); tick();
        res_valid = 0; fetch_valid = 1; fetch_pc = 32'h508; tick();
        chk("tp_ras_pred", pred_target, 32'h424);
        fetch_valid = 0;
        set_res(1, 32'h508, K_JALR, 32'h0, 0, 5'd0, 5'd1, 32'h424, 0, 1, 32'h424); tick();
        for (int c = 0; c < 5; c++) begin
            set_res(1, 32'h440 + 4 * c, K_JAL, 32'h100, 0, 5'd1, 0, 0, 0, 0, 0); tick();
        end
        for (int r = 0; r < 4; r++) begin
            set_res(1, 32'h508, K_JALR, 32'h0, 0, 5'd0, 5'd1, m_ras[$], 0, 0, 0);
            model_pred();
            fetch_valid = 1; fetch_pc = 32'h508; tick();
            fetch_valid = 0;
        end
        res_valid = 0; fetch_valid = 1; fetch_pc = 32'h508; tick();
        chk("tp_ras_overflow", pred_target, 32'h448);
        fetch_valid = 0;
`endif

        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            fetch_valid = ($urandom_range(0, 3) != 0);
            fetch_pc = pool[$urandom_range(0, 7)];
            res_valid = ($urandom_range(0, 9) < 7);
            res_pc = pool[$urandom_range(0, 7)];
            d_k = int'($urandom_range(0, 3));
            d_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: d_rd = 5'd0; 1: d_rd = 5'd1; 2: d_rd = 5'd5; default: d_rd = 5'd3;
            endcase
            case ($urandom_range(0, 3))
                0: d_rs1 = 5'd0; 1: d_rs1 = 5'd1; 2: d_rs1 = 5'd5; default: d_rs1 = 5'd2;
            endcase
            case (d_k)
                K_JAL:   d_imm = 32'(int'($urandom_range(0, 255)) - 128) * 4;
                K_JALR:  d_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                K_BR:    d_imm = 32'(int'($urandom_range(0, 63)) - 32) * 4;
                default: d_imm = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rs1_val = 0; 1: rs1_val = 1; 2: rs1_val = 5; 3: rs1_val = 32'hFFFF_FFFF; default: rs1_val = 32'h8000_0000;
            endcase
            case ($urandom_range(0, 4))
                0: rs2_val = 0; 1: rs2_val = 1; 2: rs2_val = 5; 3: rs2_val = 32'hFFFF_FFFF; default: rs2_val = 32'h8000_0000;
            endcase
            if ($urandom_range(0, 1) == 1) model_pred();
            else begin
                res_pred_taken = 1'($urandom_range(0, 1));
                res_pred_target = ($urandom_range(0, 1) == 1) ? res_pc + 4 : pool[$urandom_range(0, 7)];
            end
            tick();
        end

        fetch_valid = 0; res_valid = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
